// File: rtl/dma_model_pkg.sv
// Shared types for the simplified DMA memory model: cache-line type, byte offset of the line index,
// and the read/write FSM state encodings.
package dma_model_pkg;

    localparam int CL_WIDTH       = 512;
    localparam int CL_BYTE_OFFSET = 6;

    typedef logic [CL_WIDTH-1:0] cl_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_WAIT  = 2'd2,
        R_DONE  = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACTIVE = 2'd1,
        W_DONE   = 2'd2
    } wr_state_e;

endpackage

// File: rtl/cl_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head whenever not empty, flush empties it in one edge.
module cl_fifo
    import dma_model_pkg::*;
#(
    parameter int  WIDTH = 512,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q;
    logic             do_push_s, do_pop_s;

    // Next-state pointers and occupancy; flush wins over any push/pop in the same cycle
    always_comb begin
        do_push_s = push && !full_q && !flush;
        do_pop_s  = pop && (count_q != '0) && !flush;
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer, count and registered full-flag state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-backed far end of the simplified DMA channel: serves read transfers from, and commits write
// transfers into, a line-addressed memory; a backdoor port lets the bench preload and inspect it.
module dma_mem_responder
    import dma_model_pkg::*;
#(
    parameter int  DEPTH      = 1024,
    parameter int  FIFO_DEPTH = 8,
    parameter int  ADDR_WIDTH = 64,
    parameter int  SIZE_WIDTH = 43,
    localparam int IDXW       = $clog2(DEPTH),
    localparam int FCW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_go,
    input  logic                  rd_en,
    output logic [CL_WIDTH-1:0]   rd_data,
    output logic                  empty,
    output logic                  rd_done,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] wr_size,
    input  logic                  wr_go,
    input  logic                  wr_en,
    input  logic [CL_WIDTH-1:0]   wr_data,
    output logic                  full,
    output logic                  wr_done,
    input  logic                  bd_we,
    input  logic [IDXW-1:0]       bd_addr,
    input  logic [CL_WIDTH-1:0]   bd_wdata,
    output logic [CL_WIDTH-1:0]   bd_rdata,
    output logic                  err
);

    cl_t mem_q [DEPTH];

    rd_state_e             rd_state_q, rd_state_d;
    logic [IDXW-1:0]       rd_idx_q, rd_idx_d;
    logic [SIZE_WIDTH-1:0] rd_size_q, rd_size_d, rd_fetched_q, rd_fetched_d, rd_popped_q, rd_popped_d;
    logic                  fetch_vld_q, fetch_vld_d, rd_done_q;
    cl_t                   fetch_data_q;
    logic                  issue_s, pop_s, rd_err_s, rd_room_s;
    logic [FCW:0]          rd_occ_s;
    logic [FCW-1:0]        rfifo_count_s;
    logic                  rfifo_empty_s, rfifo_full_unused_s;

    wr_state_e             wr_state_q, wr_state_d;
    logic [IDXW-1:0]       wr_idx_q, wr_idx_d;
    logic [SIZE_WIDTH-1:0] wr_size_q, wr_size_d, wr_pushed_q, wr_pushed_d, wr_comm_q, wr_comm_d;
    logic                  wr_done_q, push_s, commit_s, wr_err_s;
    cl_t                   wfifo_dout_s;
    logic                  wfifo_empty_s, wfifo_full_s;
    logic [FCW-1:0]        wfifo_count_unused_s;

    logic                  err_q;
    cl_t                   bd_rdata_q;
    logic                  unused_s;

    cl_fifo #(.WIDTH(CL_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk(clk), .rst(rst), .flush(rd_go), .push(fetch_vld_q), .pop(pop_s), .din(fetch_data_q),
        .dout(rd_data), .full(rfifo_full_unused_s), .empty(rfifo_empty_s), .count(rfifo_count_s)
    );

    cl_fifo #(.WIDTH(CL_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk(clk), .rst(rst), .flush(wr_go), .push(push_s), .pop(commit_s), .din(wr_data),
        .dout(wfifo_dout_s), .full(wfifo_full_s), .empty(wfifo_empty_s), .count(wfifo_count_unused_s)
    );

    // Read engine: fetch only while queued plus in-flight lines still fit in the read FIFO
    always_comb begin
        rd_occ_s     = {1'b0, rfifo_count_s} + {{FCW{1'b0}}, fetch_vld_q};
        rd_room_s    = (rd_occ_s < (FCW+1)'(FIFO_DEPTH));
        issue_s      = (rd_state_q == R_FETCH) && (rd_fetched_q != rd_size_q) && rd_room_s && !rd_go;
        pop_s        = rd_en && !rfifo_empty_s && (rd_popped_q != rd_size_q) && !rd_go;
        rd_err_s     = rd_en && !rd_go && !pop_s;
        fetch_vld_d  = issue_s;
        rd_idx_d     = issue_s ? rd_idx_q + IDXW'(1) : rd_idx_q;
        rd_fetched_d = issue_s ? rd_fetched_q + SIZE_WIDTH'(1) : rd_fetched_q;
        rd_popped_d  = pop_s ? rd_popped_q + SIZE_WIDTH'(1) : rd_popped_q;
        rd_size_d    = rd_size_q;
        rd_state_d   = rd_state_q;
        case (rd_state_q)
            R_IDLE:  rd_state_d = R_IDLE;
            R_FETCH: rd_state_d = (rd_fetched_d == rd_size_q) ? R_WAIT : R_FETCH;
            R_WAIT:  rd_state_d = (rd_popped_d == rd_size_q) ? R_DONE : R_WAIT;
            R_DONE:  rd_state_d = R_DONE;
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_go) begin
            rd_idx_d     = rd_addr[CL_BYTE_OFFSET +: IDXW];
            rd_size_d    = rd_size;
            rd_fetched_d = '0;
            rd_popped_d  = '0;
            fetch_vld_d  = 1'b0;
            rd_state_d   = (rd_size == '0) ? R_DONE : R_FETCH;
        end else begin
            rd_size_d = rd_size_q;
        end
    end

    // Read engine state; done trails the DONE state by one edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q   <= R_IDLE;
            rd_idx_q     <= '0;
            rd_size_q    <= '0;
            rd_fetched_q <= '0;
            rd_popped_q  <= '0;
            fetch_vld_q  <= 1'b0;
            rd_done_q    <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            rd_idx_q     <= rd_idx_d;
            rd_size_q    <= rd_size_d;
            rd_fetched_q <= rd_fetched_d;
            rd_popped_q  <= rd_popped_d;
            fetch_vld_q  <= fetch_vld_d;
            rd_done_q    <= (rd_state_q == R_DONE);
        end
    end

    // Write engine: accept pushes only inside an open transfer, commit one line per cycle
    always_comb begin
        push_s      = wr_en && !wr_go && (wr_state_q != W_IDLE) && !wfifo_full_s && (wr_pushed_q != wr_size_q);
        wr_err_s    = wr_en && !wr_go && !push_s;
        commit_s    = (wr_state_q == W_ACTIVE) && !wfifo_empty_s && !wr_go;
        wr_pushed_d = push_s ? wr_pushed_q + SIZE_WIDTH'(1) : wr_pushed_q;
        wr_comm_d   = commit_s ? wr_comm_q + SIZE_WIDTH'(1) : wr_comm_q;
        wr_idx_d    = commit_s ? wr_idx_q + IDXW'(1) : wr_idx_q;
        wr_size_d   = wr_size_q;
        wr_state_d  = wr_state_q;
        case (wr_state_q)
            W_IDLE:   wr_state_d = W_IDLE;
            W_ACTIVE: wr_state_d = (wr_comm_d == wr_size_q) ? W_DONE : W_ACTIVE;
            W_DONE:   wr_state_d = W_DONE;
            default:  wr_state_d = W_IDLE;
        endcase
        if (wr_go) begin
            wr_idx_d    = wr_addr[CL_BYTE_OFFSET +: IDXW];
            wr_size_d   = wr_size;
            wr_pushed_d = '0;
            wr_comm_d   = '0;
            wr_state_d  = (wr_size == '0) ? W_DONE : W_ACTIVE;
        end else begin
            wr_size_d = wr_size_q;
        end
    end

    // Write engine state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q  <= W_IDLE;
            wr_idx_q    <= '0;
            wr_size_q   <= '0;
            wr_pushed_q <= '0;
            wr_comm_q   <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_idx_q    <= wr_idx_d;
            wr_size_q   <= wr_size_d;
            wr_pushed_q <= wr_pushed_d;
            wr_comm_q   <= wr_comm_d;
            wr_done_q   <= (wr_state_q == W_DONE);
        end
    end

    // Line memory: backdoor write first so a same-line commit lands last and wins; fetch sees old data
    always_ff @(posedge clk) begin
        if (bd_we) mem_q[bd_addr] <= bd_wdata;
        if (commit_s) mem_q[wr_idx_q] <= wfifo_dout_s;
        if (issue_s) fetch_data_q <= mem_q[rd_idx_q];
    end

    // Backdoor read port and sticky protocol-error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bd_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            bd_rdata_q <= mem_q[bd_addr];
            err_q      <= err_q | rd_err_s | wr_err_s;
        end
    end

    assign empty    = rfifo_empty_s;
    assign full     = wfifo_full_s;
    assign rd_done  = rd_done_q;
    assign wr_done  = wr_done_q;
    assign bd_rdata = bd_rdata_q;
    assign err      = err_q;

    assign unused_s = ^{rd_addr[ADDR_WIDTH-1:CL_BYTE_OFFSET+IDXW], rd_addr[CL_BYTE_OFFSET-1:0],
                        wr_addr[ADDR_WIDTH-1:CL_BYTE_OFFSET+IDXW], wr_addr[CL_BYTE_OFFSET-1:0],
                        rfifo_full_unused_s, wfifo_count_unused_s};

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed self-checking bench for dma_mem_responder: readback, writeback, backpressure, wrap,
// error/restart, zero-size transfers and asynchronous reset mid-write.
module tb_dma_mem_responder;
    import dma_model_pkg::*;

    localparam int DEPTH = 1024;
    localparam int IW    = 10;

    logic          clk, rst;
    logic [63:0]   rd_addr, wr_addr;
    logic [42:0]   rd_size, wr_size;
    logic          rd_go, rd_en, wr_go, wr_en, bd_we;
    cl_t           rd_data, wr_data, bd_wdata, bd_rdata;
    logic          empty, rd_done, full, wr_done, err;
    logic [IW-1:0] bd_addr;

    int  n_cmp, n_bad;
    cl_t got_data [0:31];
    int  got_n;
    cl_t exp_v, rb;

    dma_mem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(8), .ADDR_WIDTH(64), .SIZE_WIDTH(43)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_size(rd_size), .rd_go(rd_go), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
        .wr_addr(wr_addr), .wr_size(wr_size), .wr_go(wr_go), .wr_en(wr_en),
        .wr_data(wr_data), .full(full), .wr_done(wr_done),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bd_write(input int idx, input cl_t d);
        bd_we = 1'b1; bd_addr = IW'(idx); bd_wdata = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic bd_read(input int idx, output cl_t d);
        bd_addr = IW'(idx);
        @(negedge clk);
        d = bd_rdata;
    endtask

    task automatic rd_start(input logic [63:0] a, input logic [42:0] s);
        rd_addr = a; rd_size = s; rd_go = 1'b1;
        @(negedge clk);
        rd_go = 1'b0;
    endtask

    // Pops whenever data is shown, capturing lines until n are collected or the budget runs out
    task automatic drain(input int n, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            if (empty === 1'b0) begin
                got_data[got_n] = rd_data; got_n++; rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %0b want 0", full); end
        n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL rst_rd_done: got %0b want 0", rd_done); end
        n_cmp++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL rst_wr_done: got %0b want 0", wr_done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b want 0", err); end
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL rst_rd_data: got %0h want 0", rd_data); end
        n_cmp++; if (bd_rdata !== '0) begin n_bad++; $display("FAIL rst_bd_rdata: got %0h want 0", bd_rdata); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_readback();
        for (int i = 0; i < 4; i++) bd_write(i, cl_t'(32'hA0 + i));
        rd_start(64'h0, 43'd4);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rb_empty_e0: got %0b want 1", empty); end
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rb_empty_e1: got %0b want 1", empty); end
        @(negedge clk);
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL rb_empty_e2: got %0b want 0", empty); end
        drain(4, 40);
        n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL rb_count: got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            exp_v = cl_t'(32'hA0 + i);
            n_cmp++; if (got_data[i] !== exp_v) begin n_bad++; $display("FAIL rb_data[%0d]: got %0h want %0h", i, got_data[i], exp_v); end
        end
        n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL rb_done_early: got %0b want 0", rd_done); end
        @(negedge clk);
        n_cmp++; if (rd_done !== 1'b1) begin n_bad++; $display("FAIL rb_done: got %0b want 1", rd_done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rb_err: got %0b want 0", err); end
    endtask

    task automatic test_writeback();
        wr_addr = 64'h1000; wr_size = 43'd3; wr_go = 1'b1;
        @(negedge clk);
        wr_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = cl_t'(32'hB0 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        n_cmp++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL wb_done_p3: got %0b want 0", wr_done); end
        @(negedge clk);
        n_cmp++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL wb_done_p4: got %0b want 0", wr_done); end
        @(negedge clk);
        n_cmp++; if (wr_done !== 1'b1) begin n_bad++; $display("FAIL wb_done_p5: got %0b want 1", wr_done); end
        for (int i = 0; i < 3; i++) begin
            bd_read(64 + i, rb);
            exp_v = cl_t'(32'hB0 + i);
            n_cmp++; if (rb !== exp_v) begin n_bad++; $display("FAIL wb_line[%0d]: got %0h want %0h", 64 + i, rb, exp_v); end
        end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wb_err: got %0b want 0", err); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20; i++) bd_write(200 + i, cl_t'(32'hC000 + i));
        rd_start(64'd12800, 43'd20);
        repeat (30) @(negedge clk);
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %0b want 0", empty); end
        exp_v = cl_t'(32'hC000);
        n_cmp++; if (rd_data !== exp_v) begin n_bad++; $display("FAIL bp_head: got %0h want %0h", rd_data, exp_v); end
        drain(20, 200);
        n_cmp++; if (got_n !== 20) begin n_bad++; $display("FAIL bp_count: got %0d want 20", got_n); end
        for (int i = 0; i < 20; i++) begin
            exp_v = cl_t'(32'hC000 + i);
            n_cmp++; if (got_data[i] !== exp_v) begin n_bad++; $display("FAIL bp_data[%0d]: got %0h want %0h", i, got_data[i], exp_v); end
        end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bp_err: got %0b want 0", err); end
    endtask

    task automatic test_wrap();
        bd_write(DEPTH - 1, cl_t'(32'hD1FF));
        rd_start(64'hFFC5, 43'd2);
        drain(2, 30);
        n_cmp++; if (got_n !== 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", got_n); end
        exp_v = cl_t'(32'hD1FF);
        n_cmp++; if (got_data[0] !== exp_v) begin n_bad++; $display("FAIL wrap_first: got %0h want %0h", got_data[0], exp_v); end
        exp_v = cl_t'(32'hA0);
        n_cmp++; if (got_data[1] !== exp_v) begin n_bad++; $display("FAIL wrap_second: got %0h want %0h", got_data[1], exp_v); end
    endtask

    task automatic test_errors_restart();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %0b want 1", err); end
        rd_start(64'h0, 43'd4);
        n_cmp++; if (rd_done !== 1'b1) begin n_bad++; $display("FAIL done_hold_e0: got %0b want 1", rd_done); end
        @(negedge clk);
        n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL done_drop: got %0b want 0", rd_done); end
        repeat (3) @(negedge clk);
        rd_start(64'd12800, 43'd3);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL restart_flush: got %0b want 1", empty); end
        drain(3, 30);
        n_cmp++; if (got_n !== 3) begin n_bad++; $display("FAIL restart_count: got %0d want 3", got_n); end
        for (int i = 0; i < 3; i++) begin
            exp_v = cl_t'(32'hC000 + i);
            n_cmp++; if (got_data[i] !== exp_v) begin n_bad++; $display("FAIL restart_data[%0d]: got %0h want %0h", i, got_data[i], exp_v); end
        end
        n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL restart_done_early: got %0b want 0", rd_done); end
        @(negedge clk);
        n_cmp++; if (rd_done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %0b want 1", rd_done); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", err); end
    endtask

    task automatic test_size_zero();
        rd_start(64'h0, 43'd5);
        @(negedge clk); @(negedge clk);
        n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL sz0_pre: got %0b want 0", rd_done); end
        rd_start(64'h0, 43'd0);
        n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL sz0_e0: got %0b want 0", rd_done); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL sz0_empty: got %0b want 1", empty); end
        @(negedge clk);
        n_cmp++; if (rd_done !== 1'b1) begin n_bad++; $display("FAIL sz0_done: got %0b want 1", rd_done); end
    endtask

    task automatic test_async_reset();
        bd_write(300, cl_t'(32'h55AA));
        bd_write(301, cl_t'(32'h55AB));
        rd_start(64'h0, 43'd2);
        repeat (3) @(negedge clk);
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL ar_pre_empty: got %0b want 0", empty); end
        wr_addr = 64'd19200; wr_size = 43'd4; wr_go = 1'b1;
        @(negedge clk);
        wr_go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = cl_t'(32'hE0 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL ar_full: got %0b want 0", full); end
        n_cmp++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL ar_wr_done: got %0b want 0", wr_done); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ar_empty: got %0b want 1", empty); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ar_err: got %0b want 0", err); end
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL ar_rd_data: got %0h want 0", rd_data); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bd_read(300, rb);
        exp_v = cl_t'(32'hE0);
        n_cmp++; if (rb !== exp_v) begin n_bad++; $display("FAIL ar_line300: got %0h want %0h", rb, exp_v); end
        bd_read(301, rb);
        exp_v = cl_t'(32'h55AB);
        n_cmp++; if (rb !== exp_v) begin n_bad++; $display("FAIL ar_line301: got %0h want %0h", rb, exp_v); end
        wr_en = 1'b1; wr_data = cl_t'(32'hEE);
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wr_idle_err: got %0b want 1", err); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; got_n = 0;
        rst = 1'b0;
        rd_addr = '0; rd_size = '0; rd_go = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_size = '0; wr_go = 1'b0; wr_en = 1'b0; wr_data = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        exp_v = '0; rb = '0;
        test_reset();
        test_readback();
        test_writeback();
        test_backpressure();
        test_wrap();
        test_errors_restart();
        test_size_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
